// File: rtl/array_mp.sv
// ---------------------------------------------------------------------------
// array_mp -- multi-read-port register array for cache tag/valid/dirty/LRU.
//
// Holds num_sets = 2**s_index entries of `width` bits, each with a valid bit.
// Writes are segment-masked (num_seg segments of width/num_seg bits) and are
// forwarded to any read port addressing the same index in the same cycle.
// A flush request starts a sweep that clears one valid bit per cycle. Data is
// never touched by the sweep.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   read       per-port read strobe                  [num_rports]
//   rindex     per-port read index, port p at [p*s_index +: s_index]
//   load       write strobe (ignored while busy)
//   windex     write index
//   wmask      write segment enables                 [num_seg]
//   datain     write data                            [width]
//   flush      request to invalidate every entry
//   dataout    per-port registered read data, port p at [p*width +: width]
//   valid_out  per-port registered valid bit
//   busy       high while a flush sweep is in progress
// ---------------------------------------------------------------------------
module array_mp #(
    parameter int s_index    = 3,
    parameter int width      = 32,
    parameter int num_seg    = 4,
    parameter int num_rports = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_rports-1:0]         read,
    input  logic [num_rports*s_index-1:0] rindex,
    input  logic                          load,
    input  logic [s_index-1:0]            windex,
    input  logic [num_seg-1:0]            wmask,
    input  logic [width-1:0]              datain,
    input  logic                          flush,
    output logic [num_rports*width-1:0]   dataout,
    output logic [num_rports-1:0]         valid_out,
    output logic                          busy
);

    localparam int num_sets = 2**s_index;
    localparam int seg_w    = width / num_seg;
    localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state, state_next;
    logic [s_index-1:0] ptr, ptr_next;

    logic [width-1:0]    mem [num_sets];
    logic [num_sets-1:0] valid;

    logic             we;      // a write that actually lands this cycle
    logic [width-1:0] merged;  // entry windex after applying the masked write

    assign busy = (state == SWEEP);
    assign we   = load && !busy && (|wmask);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        merged = mem[windex];
        for (int k = 0; k < num_seg; k++) begin
            if (wmask[k]) merged[k*seg_w +: seg_w] = datain[k*seg_w +: seg_w];
        end
    end

    // ---------------- flush sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of process ordering.
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                // Flush requests are ignored here; the sweep never restarts.
                ptr_next = ptr + 1'b1;
                if (ptr == last_set) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array contents are architecturally zero after reset,
            // so the storage is reset like ordinary flops, not left as RAM.
            for (int i = 0; i < num_sets; i++) mem[i] <= '0;
            valid <= '0;
        end else begin
            if (we) begin
                mem[windex]   <= merged;
                valid[windex] <= 1'b1;
            end
            // Writes are blocked while sweeping, so these never collide.
            if (busy) valid[ptr] <= 1'b0;
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < num_rports; p++) begin : g_port
        logic [s_index-1:0] rd_idx;
        assign rd_idx = rindex[p*s_index +: s_index];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dataout[p*width +: width] <= '0;
                valid_out[p]              <= 1'b0;
            end else if (read[p]) begin
                if (we && (rd_idx == windex)) begin
                    // Write-to-read bypass: the merged word is what the entry
                    // holds after this edge, and it is now valid.
                    dataout[p*width +: width] <= merged;
                    valid_out[p]              <= 1'b1;
                end else begin
                    // The entry being cleared this cycle already reads as
                    // invalid.
                    dataout[p*width +: width] <= mem[rd_idx];
                    valid_out[p]              <= valid[rd_idx] &&
                                                 !(busy && (rd_idx == ptr));
                end
            end
        end
    end

endmodule

// File: doc/array_mp.md
Name: array_mp

Overview:
- Parametrised multi-read-port register array for cache tag, valid, dirty and LRU storage.
- Generalises the single-port array: N independent registered read ports, segment-masked writes with write-to-read bypass, per-entry valid bits and a sequenced flush that invalidates one set per cycle.
- Sits beside the cache datapath. The control FSM drives it. Flush is driven by the fence/invalidate path.

Parameters:
- s_index, 3, index width; num_sets = 2**s_index.
- width, 32, entry width in bits.
- num_seg, 4, write-mask segments; width must be a multiple of num_seg; seg_w = width/num_seg.
- num_rports, 2, number of independent read ports (1 to 4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset; array is in reset while rst=0.
- read  in  num_rports  per-port read strobe.
- rindex  in  num_rports*s_index  per-port read index; port p occupies bits [p*s_index +: s_index].
- load  in  1  write strobe.
- windex  in  s_index  write index.
- wmask  in  num_seg  write segment enables; bit k covers datain[k*seg_w +: seg_w].
- datain  in  width  write data.
- flush  in  1  request to invalidate all entries.
- dataout  out  num_rports*width  per-port registered read data.
- valid_out  out  num_rports  per-port registered valid bit of the entry read.
- busy  out  1  high while a flush sweep is in progress.

Behaviour:
- Reset (rst=0, asynchronous): all data entries = 0, all valid bits = 0, dataout = 0, valid_out = 0, busy = 0, state = IDLE, flush pointer = 0. Reset asserted mid-flush aborts the sweep; after reset the state is IDLE.
- Read, 1-cycle latency:
  - On a rising edge with read[p]=1, dataout[p] and valid_out[p] capture entry rindex[p].
  - With read[p]=0, dataout[p] and valid_out[p] hold their previous values.
  - Each port is fully independent; any number of ports may read the same index.
- Write (IDLE only):
  - On a rising edge with load=1 and busy=0, each segment k with wmask[k]=1 takes datain; segments with wmask[k]=0 keep their old value.
  - valid[windex] is set to 1 when wmask != 0.
  - load with wmask=0 is a no-op.
- Bypass:
  - Condition: read[p]=1, load=1, busy=0 and rindex[p]==windex in the same cycle.
  - dataout[p] = merged word (new segments where wmask=1, old segments elsewhere).
  - valid_out[p] = old valid OR (wmask != 0).
  - Each port evaluates bypass independently.
- Flush FSM, states IDLE and SWEEP:
  - IDLE with flush=1: go to SWEEP with pointer=0; busy=1 from the next cycle.
  - SWEEP, each cycle: valid[pointer] <= 0 and the pointer increments.
  - When pointer == num_sets-1 is cleared, return to IDLE. busy is high for exactly num_sets cycles.
  - Data contents are never modified by flush.
  - flush asserted while busy is ignored; the sweep does not restart.
  - flush held high after the sweep finishes starts a new sweep.
  - load during SWEEP is dropped: no data or valid change, and no bypass.
- Reads during SWEEP:
  - Reads proceed normally and see the current valid bits.
  - Reading the index cleared in that same cycle returns valid_out=0 (clear-bypass).
  - Reading an index not yet swept returns its old valid bit.
- Width rules:
  - Index compares use the full s_index bits.
  - No wrap is needed on the pointer beyond num_sets-1, because the FSM exits at that value.

Test Plan:
- Reset, then read all 8 sets on both ports -> dataout=0, valid_out=0 for every index; busy=0.
- Write windex=5, datain=0xDEADBEEF, wmask=4'b1111; next cycle write wmask=4'b0001, datain=0x000000AA; then read 5 -> dataout=0xDEADBEAA, valid_out=1.
- Same cycle: load windex=2, wmask=4'b1100, datain=0x12340000, with old entry 0x0000FFFF; read port0 rindex=2, read port1 rindex=3 -> next cycle port0=0x1234FFFF (bypass), port1=old entry 3.
- Fill all sets valid, then pulse flush -> busy high for exactly 8 cycles; a load to index 6 on cycle 3 of the sweep is dropped; after the sweep every valid_out=0 and the data is unchanged.
- During the sweep read index 0 on cycle 1 -> valid_out=0; read index 7 on cycle 2 -> valid_out=1; flush re-pulsed mid-sweep -> busy still lasts 8 cycles total.
- Assert rst low asynchronously mid-sweep, between clock edges -> outputs, busy and valid bits clear immediately; after release busy=0 and a read of any index returns 0.
